cp0_except_ctrl: RTL and testbench
==================================

// Module: cp0_except_ctrl
// PURPOSE
//  - WB-stage exception/ERET controller. It is the producer side of the CP0 register block's event interface.
//  - Latches the MEM->WB bundle and prioritises the exception flags against pending interrupts.
//  - Drives wb_ex/wb_exccode/wb_bd/wb_pc/wb_badvaddr and eret_reflush into CP0.
//  - Holds a pipeline flush/redirect request to fetch until fetch acknowledges it.
// PARAMETERS
//  EX_ENTRY  32'hbfc00380  exception vector (BEV=1)
//  INT_EN    1             1: interrupts are evaluated; 0: the Int term is forced to 0
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous active-high reset
//  ms_to_ws_valid  in   1   MEM offers an instruction
//  ws_allowin      out  1   WB accepts it this cycle
//  ms_pc           in   32  instruction PC
//  ms_bd           in   1   instruction is in a delay slot
//  ms_ex_vec       in   7   [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-load [6]AdES
//  ms_badvaddr     in   32  faulting address for AdEL/AdES
//  ms_eret         in   1   instruction is ERET
//  cp0_status      in   32  CP0 Status (IE=bit0, EXL=bit1, IM=15:8)
//  cp0_cause       in   32  CP0 Cause (IP=15:8)
//  cp0_epc         in   32  CP0 EPC
//  wb_ex           out  1   one-cycle exception commit to CP0
//  wb_exccode      out  5   ExcCode for wb_ex
//  wb_bd           out  1   BD of the excepting instruction
//  wb_pc           out  32  PC of the excepting instruction
//  wb_badvaddr     out  32  BadVAddr value (valid with AdEL/AdES)
//  eret_reflush    out  1   one-cycle ERET commit to CP0
//  ws_retire       out  1   normal retire (regfile write enable qualifier)
//  flush_req       out  1   flush the pipeline and redirect fetch
//  flush_target    out  32  redirect PC
//  fs_redirect_ack in   1   fetch has taken the redirect
// BEHAVIOUR
//  - WB latch:
//    - On (ms_to_ws_valid & ws_allowin & state==IDLE), ws_valid<=1 and the bundle is registered.
//    - Otherwise, if ws_allowin is high, ws_valid<=0.
//    - ws_allowin=1 always. Instructions presented while state==REDIRECT are discarded (squashed).
//  - int_pend = INT_EN & IE & ~EXL & |(IM & IP). It is sampled against the WB instruction, not the ack.
//  - Priority: Int(0x00) > AdEL-fetch(0x04) > RI(0x0a) > Ov(0x0c) > Sys(0x08) > Bp(0x09) > AdEL-load(0x04) > AdES(0x05).
//  - take_ex = ws_valid & IDLE & (int_pend | |ms_ex_vec). Exception beats ERET.
//    - wb_ex = take_ex.
//    - eret_reflush = ws_valid & IDLE & eret & ~take_ex.
//    - ws_retire = ws_valid & IDLE & ~take_ex & ~eret.
//    - All three are combinational from registered state; zero latency after the WB latch.
//  - wb_badvaddr: AdEL-fetch gives ws_pc; AdEL-load/AdES give the registered ms_badvaddr; otherwise 0.
//  - FSM IDLE/REDIRECT:
//    - IDLE -> REDIRECT on wb_ex or eret_reflush.
//      - flush_target <= EX_ENTRY on exception.
//      - flush_target <= cp0_epc sampled in the commit cycle on ERET.
//    - REDIRECT: flush_req=1 and flush_target is held.
//    - REDIRECT -> IDLE on fs_redirect_ack. flush_req drops the next cycle.
//    - An ack is ignored while flush_req=0.
//    - No second commit is possible until back in IDLE.
//  - Reset:
//    - ws_valid=0 and state=IDLE.
//    - flush_req, wb_ex, eret_reflush, ws_retire = 0.
//    - flush_target = 0 and all registered bundle fields = 0.
//    - Reset while in REDIRECT abandons the redirect.
//  - wb_pc is the raw PC. The BD adjustment is CP0's job.
// TESTING
//  1. Sys at pc=0xbfc00100, bd=0:
//     - wb_ex=1 for 1 cycle with code 0x08 and wb_pc=0xbfc00100.
//     - Next cycle flush_req=1, target=0xbfc00380.
//     - Held until ack.
//  2. ERET with cp0_epc=0xbfc00200:
//     - eret_reflush pulse.
//     - flush_target=0xbfc00200.
//     - MEM instructions offered during REDIRECT are never retired.
//  3. IE=1, EXL=0, IM[7]=IP[7]=1, RI instruction in WB:
//     - wb_ex with code 0x00.
//     - With EXL=1 instead, code 0x0a.
//  4. AdEL-fetch and Ov both set:
//     - Code 0x04 and wb_badvaddr=ws_pc.
//     - AdES alone gives code 0x05 and wb_badvaddr=ms_badvaddr.
//  5. ERET with RI also flagged:
//     - wb_ex=1 with code 0x0a; eret_reflush=0.
//  6. rst asserted during REDIRECT:
//     - Next cycle flush_req=0 and IDLE.
//     - An ack while flush_req=0 leaves the state unchanged.

Source files
------------

// File: rtl/cp0_except_ctrl.sv
// WB-stage exception/ERET controller: latches the MEM->WB bundle, prioritises
// exceptions against interrupts, commits to CP0 and holds a fetch redirect until acked.
module cp0_except_ctrl #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  parameter logic        INT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_bd,
  input  logic [6:0]  ms_ex_vec,
  input  logic [31:0] ms_badvaddr,
  input  logic        ms_eret,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        wb_ex,
  output logic [4:0]  wb_exccode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        eret_reflush,
  output logic        ws_retire,
  output logic        flush_req,
  output logic [31:0] flush_target,
  input  logic        fs_redirect_ack
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [6:0]  ws_ex_vec;
  logic [31:0] ws_badvaddr;
  logic        ws_eret;
  logic        int_pend;
  logic        take_ex;
  logic        eret_commit;
  logic [4:0]  exc_code_sel;
  logic [31:0] badvaddr_sel;
  logic        unused_bits;

  // Ex-vector bits are ordered by priority: lowest set bit wins after Int.
  function automatic logic [4:0] exc_code(input logic intp, input logic [6:0] ex);
    if (intp)       exc_code = 5'h00;
    else if (ex[0]) exc_code = 5'h04;
    else if (ex[1]) exc_code = 5'h0a;
    else if (ex[2]) exc_code = 5'h0c;
    else if (ex[3]) exc_code = 5'h08;
    else if (ex[4]) exc_code = 5'h09;
    else if (ex[5]) exc_code = 5'h04;
    else if (ex[6]) exc_code = 5'h05;
    else            exc_code = 5'h00;
  endfunction

  function automatic logic [31:0] bad_addr(input logic intp, input logic [6:0] ex,
                                           input logic [31:0] pc, input logic [31:0] va);
    if (intp)                bad_addr = 32'h0;
    else if (ex[0])          bad_addr = pc;
    else if (|ex[4:1])       bad_addr = 32'h0;
    else if (ex[5] | ex[6])  bad_addr = va;
    else                     bad_addr = 32'h0;
  endfunction

  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  // WB latch: accept only while IDLE, so anything offered during a redirect is squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid    <= 1'b0;
      ws_pc       <= 32'h0;
      ws_bd       <= 1'b0;
      ws_ex_vec   <= 7'h0;
      ws_badvaddr <= 32'h0;
      ws_eret     <= 1'b0;
    end else if (ms_to_ws_valid && ws_allowin && state == IDLE) begin
      ws_valid    <= 1'b1;
      ws_pc       <= ms_pc;
      ws_bd       <= ms_bd;
      ws_ex_vec   <= ms_ex_vec;
      ws_badvaddr <= ms_badvaddr;
      ws_eret     <= ms_eret;
    end else if (ws_allowin) begin
      ws_valid    <= 1'b0;
    end else begin
      ws_valid    <= ws_valid;
    end
  end

  // State register and redirect target; the EPC is captured in the ERET commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_target <= 32'h0;
    end else begin
      state <= state_nxt;
      if (take_ex)
        flush_target <= EX_ENTRY;
      else if (eret_commit)
        flush_target <= cp0_epc;
      else
        flush_target <= flush_target;
    end
  end

  // Next-state: acks only matter while a redirect is outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_ex || eret_commit) state_nxt = REDIRECT;
                else                        state_nxt = IDLE;
      REDIRECT: if (fs_redirect_ack)        state_nxt = IDLE;
                else                        state_nxt = REDIRECT;
      default:  state_nxt = IDLE;
    endcase
  end

  // Commit outputs, decoded from the registered WB bundle and state.
  always_comb begin
    int_pend     = INT_EN & cp0_status[0] & ~cp0_status[1]
                   & (|(cp0_status[15:8] & cp0_cause[15:8]));
    take_ex      = ws_valid & (state == IDLE) & (int_pend | (|ws_ex_vec));
    eret_commit  = ws_valid & (state == IDLE) & ws_eret & ~take_ex;
    exc_code_sel = exc_code(int_pend, ws_ex_vec);
    badvaddr_sel = bad_addr(int_pend, ws_ex_vec, ws_pc, ws_badvaddr);
    ws_allowin   = 1'b1;
    wb_ex        = take_ex;
    wb_exccode   = take_ex ? exc_code_sel : 5'h00;
    wb_badvaddr  = take_ex ? badvaddr_sel : 32'h0;
    wb_bd        = ws_bd;
    wb_pc        = ws_pc;
    eret_reflush = eret_commit;
    ws_retire    = ws_valid & (state == IDLE) & ~take_ex & ~ws_eret;
    flush_req    = (state == REDIRECT);
  end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed and randomized checks of cp0_except_ctrl against a behavioural model.
module tb_cp0_except_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ms_to_ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ms_pc = 32'h0;
  logic        ms_bd = 1'b0;
  logic [6:0]  ms_ex_vec = 7'h0;
  logic [31:0] ms_badvaddr = 32'h0;
  logic        ms_eret = 1'b0;
  logic [31:0] cp0_status = 32'h0;
  logic [31:0] cp0_cause = 32'h0;
  logic [31:0] cp0_epc = 32'h0;
  logic        wb_ex;
  logic [4:0]  wb_exccode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_reflush;
  logic        ws_retire;
  logic        flush_req;
  logic [31:0] flush_target;
  logic        fs_redirect_ack = 1'b0;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic        m_valid, m_bd, m_eret, m_redir;
  logic [31:0] m_pc, m_bva, m_target;
  logic [6:0]  m_ex;
  logic        e_int, e_take, e_eret;
  logic [4:0]  e_code;
  logic [31:0] e_bva;
  logic [4:0]  code_tab [7];

  cp0_except_ctrl dut (
    .clk(clk), .rst(rst), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex_vec(ms_ex_vec), .ms_badvaddr(ms_badvaddr),
    .ms_eret(ms_eret), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .wb_ex(wb_ex), .wb_exccode(wb_exccode), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_reflush(eret_reflush), .ws_retire(ws_retire),
    .flush_req(flush_req), .flush_target(flush_target), .fs_redirect_ack(fs_redirect_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic bd, input logic [6:0] ex,
                       input logic [31:0] bva, input logic eret);
    ms_to_ws_valid = 1'b1;
    ms_pc = pc; ms_bd = bd; ms_ex_vec = ex; ms_badvaddr = bva; ms_eret = eret;
  endtask

  // Takes the redirect from the cycle after a commit through the ack.
  task automatic finish_redirect();
    tick();
    fs_redirect_ack = 1'b1;
    tick();
    fs_redirect_ack = 1'b0;
  endtask

  initial begin
    code_tab = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

    tick(); tick();
    chk("rst_flush_req", {31'h0, flush_req}, 32'h0);
    chk("rst_wb_ex", {31'h0, wb_ex}, 32'h0);
    chk("rst_retire", {31'h0, ws_retire}, 32'h0);
    chk("rst_eret", {31'h0, eret_reflush}, 32'h0);
    chk("rst_target", flush_target, 32'h0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("allowin", {31'h0, ws_allowin}, 32'h1);
    rst = 1'b0;

    // 1: Sys commit and held redirect
    offer(32'hbfc00100, 1'b0, 7'h08, 32'h0, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t1_wb_ex", {31'h0, wb_ex}, 32'h1);
    chk("t1_code", {27'h0, wb_exccode}, 32'h08);
    chk("t1_pc", wb_pc, 32'hbfc00100);
    chk("t1_bd", {31'h0, wb_bd}, 32'h0);
    chk("t1_no_flush_yet", {31'h0, flush_req}, 32'h0);
    tick();
    chk("t1_ex_pulse", {31'h0, wb_ex}, 32'h0);
    chk("t1_flush", {31'h0, flush_req}, 32'h1);
    chk("t1_target", flush_target, 32'hbfc00380);
    tick();
    chk("t1_flush_held", {31'h0, flush_req}, 32'h1);
    fs_redirect_ack = 1'b1; tick(); fs_redirect_ack = 1'b0; #1;
    chk("t1_flush_drop", {31'h0, flush_req}, 32'h0);

    // 2: ERET, instructions offered during the redirect are squashed
    cp0_epc = 32'hbfc00200;
    offer(32'hbfc00104, 1'b0, 7'h00, 32'h0, 1'b1);
    tick(); offer(32'hbfc00108, 1'b0, 7'h00, 32'h0, 1'b0); #1;
    chk("t2_eret", {31'h0, eret_reflush}, 32'h1);
    chk("t2_no_ex", {31'h0, wb_ex}, 32'h0);
    chk("t2_no_retire0", {31'h0, ws_retire}, 32'h0);
    tick();
    chk("t2_flush", {31'h0, flush_req}, 32'h1);
    chk("t2_target", flush_target, 32'hbfc00200);
    chk("t2_eret_pulse", {31'h0, eret_reflush}, 32'h0);
    chk("t2_no_retire1", {31'h0, ws_retire}, 32'h0);
    tick();
    chk("t2_no_retire2", {31'h0, ws_retire}, 32'h0);
    fs_redirect_ack = 1'b1; tick(); fs_redirect_ack = 1'b0; ms_to_ws_valid = 1'b0; #1;
    chk("t2_flush_drop", {31'h0, flush_req}, 32'h0);
    chk("t2_no_retire3", {31'h0, ws_retire}, 32'h0);

    // 3: interrupt beats RI unless EXL is set
    cp0_status = 32'h00008001; cp0_cause = 32'h00008000;
    offer(32'h00400000, 1'b0, 7'h02, 32'h0, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t3_int_ex", {31'h0, wb_ex}, 32'h1);
    chk("t3_int_code", {27'h0, wb_exccode}, 32'h00);
    finish_redirect();
    cp0_status = 32'h00008003;
    offer(32'h00400004, 1'b1, 7'h02, 32'h0, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t3_exl_code", {27'h0, wb_exccode}, 32'h0a);
    chk("t3_exl_bd", {31'h0, wb_bd}, 32'h1);
    finish_redirect();
    cp0_status = 32'h0; cp0_cause = 32'h0;

    // 4: AdEL-fetch over Ov, then AdES alone
    offer(32'h10000004, 1'b0, 7'h05, 32'h12345678, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t4_adel_code", {27'h0, wb_exccode}, 32'h04);
    chk("t4_adel_bva", wb_badvaddr, 32'h10000004);
    finish_redirect();
    offer(32'h10000008, 1'b0, 7'h40, 32'hdeadbeef, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t4_ades_code", {27'h0, wb_exccode}, 32'h05);
    chk("t4_ades_bva", wb_badvaddr, 32'hdeadbeef);
    finish_redirect();

    // 5: ERET with RI flagged takes the exception
    offer(32'h2000000c, 1'b0, 7'h02, 32'h0, 1'b1);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t5_ex", {31'h0, wb_ex}, 32'h1);
    chk("t5_code", {27'h0, wb_exccode}, 32'h0a);
    chk("t5_no_eret", {31'h0, eret_reflush}, 32'h0);
    finish_redirect();

    // 6: reset abandons a redirect; a stray ack leaves IDLE alone
    offer(32'h30000000, 1'b0, 7'h08, 32'h0, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; tick();
    chk("t6_flush", {31'h0, flush_req}, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("t6_rst_flush", {31'h0, flush_req}, 32'h0);
    chk("t6_rst_target", flush_target, 32'h0);
    fs_redirect_ack = 1'b1; tick(); fs_redirect_ack = 1'b0; #1;
    chk("t6_ack_idle", {31'h0, flush_req}, 32'h0);
    offer(32'h30000004, 1'b0, 7'h00, 32'h0, 1'b0);
    tick(); ms_to_ws_valid = 1'b0; #1;
    chk("t6_retire", {31'h1 & 32'h0, ws_retire}, 32'h1);
    tick();

    // Randomized phase against the behavioural model
    m_valid = 1'b0; m_redir = 1'b0; m_target = 32'h0;
    m_pc = 32'h0; m_bd = 1'b0; m_ex = 7'h0; m_bva = 32'h0; m_eret = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ms_to_ws_valid  = ($urandom_range(0, 3) != 0);
      ms_pc           = $urandom;
      ms_bd           = $urandom_range(0, 1) == 1;
      ms_ex_vec       = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
      ms_badvaddr     = $urandom;
      ms_eret         = ($urandom_range(0, 4) == 0);
      cp0_status      = $urandom;
      cp0_cause       = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
      cp0_epc         = $urandom;
      fs_redirect_ack = ($urandom_range(0, 2) == 0);
      #1;
      e_int  = cp0_status[0] && !cp0_status[1] && ((cp0_status[15:8] & cp0_cause[15:8]) != 8'h0);
      e_take = m_valid && !m_redir && (e_int || m_ex != 7'h0);
      e_eret = m_valid && !m_redir && m_eret && !e_take;
      e_code = 5'h00;
      e_bva  = 32'h0;
      if (!e_int) begin
        for (int b = 6; b >= 0; b--) begin
          if (m_ex[b]) begin
            e_code = code_tab[b];
            e_bva  = (b == 0) ? m_pc : ((b >= 5) ? m_bva : 32'h0);
          end
        end
      end
      chk("rnd_wb_ex", {31'h0, wb_ex}, {31'h0, e_take});
      chk("rnd_eret", {31'h0, eret_reflush}, {31'h0, e_eret});
      chk("rnd_retire", {31'h0, ws_retire}, {31'h0, m_valid && !m_redir && !e_take && !m_eret});
      chk("rnd_flush", {31'h0, flush_req}, {31'h0, m_redir});
      if (m_redir) chk("rnd_target", flush_target, m_target);
      if (e_take) begin
        chk("rnd_code", {27'h0, wb_exccode}, {27'h0, e_code});
        chk("rnd_bva", wb_badvaddr, e_bva);
        chk("rnd_pc", wb_pc, m_pc);
        chk("rnd_bd", {31'h0, wb_bd}, {31'h0, m_bd});
      end
      if (m_redir) begin
        if (fs_redirect_ack) m_redir = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (e_take || e_eret) begin
          m_redir  = 1'b1;
          m_target = e_take ? 32'hbfc00380 : cp0_epc;
        end
        m_valid = ms_to_ws_valid;
        if (ms_to_ws_valid) begin
          m_pc = ms_pc; m_bd = ms_bd; m_ex = ms_ex_vec; m_bva = ms_badvaddr; m_eret = ms_eret;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
